// File: rtl/mlu_pkg.sv
// rtl/mlu_pkg.sv - shared mode encoding and width helpers for the MLU pipeline
package mlu_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MLU_CNT  = 3'd0,
        MLU_ADD  = 3'd1,
        MLU_SUB  = 3'd2,
        MLU_MUL  = 3'd3,
        MLU_DOT  = 3'd4,
        MLU_DIST = 3'd5
    } mlu_mode_e;

    function automatic int prod_width(input int dw);
        return 2 * dw;
    endfunction

    function automatic int tree_width(input int dw, input int lanes);
        return 2 * dw + $clog2(lanes);
    endfunction

    function automatic logic is_reduce(input logic [MODE_W-1:0] m);
        return (m == MLU_CNT) || (m == MLU_DOT) || (m == MLU_DIST);
    endfunction

endpackage

// File: rtl/mlu_lane.sv
// rtl/mlu_lane.sv - combinational single-lane operator at 2*DATA_WIDTH signed precision
module mlu_lane
    import mlu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0]   hot,
    input  logic [DATA_WIDTH-1:0]   cold,
    input  logic [MODE_W-1:0]       mode,
    output logic [2*DATA_WIDTH-1:0] res
);

    localparam int PW = prod_width(DATA_WIDTH);

    logic signed [PW-1:0] hot_w;
    logic signed [PW-1:0] cold_w;
    logic signed [PW-1:0] diff_w;

    always_comb begin
        hot_w  = {{DATA_WIDTH{hot[DATA_WIDTH-1]}}, hot};
        cold_w = {{DATA_WIDTH{cold[DATA_WIDTH-1]}}, cold};
        diff_w = hot_w - cold_w;
        res    = '0;
        case (mode)
            MLU_CNT:          res = (hot == cold) ? PW'(1) : '0;
            MLU_ADD:          res = hot_w + cold_w;
            MLU_SUB:          res = diff_w;
            MLU_MUL, MLU_DOT: res = hot_w * cold_w;
            MLU_DIST:         res = diff_w * diff_w;
            default:          res = '0;
        endcase
    end

endmodule

// File: rtl/mlu_pipe.sv
// rtl/mlu_pipe.sv - three-stage vector/reduce unit: lane ops, adder tree, saturating accumulator
module mlu_pipe
    import mlu_pkg::*;
#(
    parameter int LANES      = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]      hot_in,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]      cold_in,
    input  logic [MODE_W-1:0]                     mode,
    input  logic                                  in_valid,
    input  logic                                  in_last,
    output logic                                  in_ready,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LANES-1:0][2*DATA_WIDTH-1:0]    out_vector,
    output logic [ACC_WIDTH-1:0]                  out_scalar,
    output logic                                  out_last,
    output logic                                  out_sat
);

    localparam int PW = prod_width(DATA_WIDTH);
    localparam int TW = tree_width(DATA_WIDTH, LANES);
    localparam int WW = ((ACC_WIDTH > TW) ? ACC_WIDTH : TW) + 1;

    localparam logic signed [WW-1:0] ACC_MAX_W = {{(WW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] ACC_MIN_W = {{(WW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic                       en;
    logic                       accept;
    logic [MODE_W-1:0]          eff_mode;
    logic [LANES-1:0][PW-1:0]   lane_res;
    logic signed [TW-1:0]       tree_sum;
    logic signed [WW-1:0]       acc_sum;
    logic                       ovf_hi;
    logic                       ovf_lo;
    logic [ACC_WIDTH-1:0]       acc_next;

    logic                       grp_open_q, grp_open_d;
    logic [MODE_W-1:0]          grp_mode_q, grp_mode_d;
    logic                       s1_valid_q, s1_valid_d;
    logic                       s1_last_q, s1_last_d;
    logic [MODE_W-1:0]          s1_mode_q, s1_mode_d;
    logic [LANES-1:0][PW-1:0]   s1_res_q, s1_res_d;
    logic                       s2_valid_q, s2_valid_d;
    logic                       s2_last_q, s2_last_d;
    logic [MODE_W-1:0]          s2_mode_q, s2_mode_d;
    logic [LANES-1:0][PW-1:0]   s2_vec_q, s2_vec_d;
    logic signed [TW-1:0]       s2_sum_q, s2_sum_d;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic                       sat_q, sat_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_last_q, out_last_d;
    logic                       out_sat_q, out_sat_d;
    logic [LANES-1:0][PW-1:0]   out_vector_q, out_vector_d;
    logic [ACC_WIDTH-1:0]       out_scalar_q, out_scalar_d;

    // The whole pipeline shares one enable: it freezes only while an output beat waits.
    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en && !rst;
    assign accept   = in_valid && in_ready;
    assign eff_mode = grp_open_q ? grp_mode_q : mode;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mlu_lane #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .hot  (hot_in[i]),
            .cold (cold_in[i]),
            .mode (eff_mode),
            .res  (lane_res[i])
        );
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + {{(TW-PW){s1_res_q[i][PW-1]}}, s1_res_q[i]};
        end

        acc_sum  = {{(WW-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q}
                 + {{(WW-TW){s2_sum_q[TW-1]}}, s2_sum_q};
        ovf_hi   = acc_sum > ACC_MAX_W;
        ovf_lo   = acc_sum < ACC_MIN_W;
        acc_next = ovf_hi ? ACC_MAX : (ovf_lo ? ACC_MIN : acc_sum[ACC_WIDTH-1:0]);

        grp_open_d   = grp_open_q;
        grp_mode_d   = grp_mode_q;
        s1_valid_d   = s1_valid_q;
        s1_last_d    = s1_last_q;
        s1_mode_d    = s1_mode_q;
        s1_res_d     = s1_res_q;
        s2_valid_d   = s2_valid_q;
        s2_last_d    = s2_last_q;
        s2_mode_d    = s2_mode_q;
        s2_vec_d     = s2_vec_q;
        s2_sum_d     = s2_sum_q;
        acc_d        = acc_q;
        sat_d        = sat_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_sat_d    = out_sat_q;
        out_vector_d = out_vector_q;
        out_scalar_d = out_scalar_q;

        if (accept) begin
            grp_open_d = !in_last;
            grp_mode_d = eff_mode;
        end

        if (en) begin
            s1_valid_d  = accept;
            s1_last_d   = in_last;
            s1_mode_d   = eff_mode;
            s1_res_d    = lane_res;
            s2_valid_d  = s1_valid_q;
            s2_last_d   = s1_last_q;
            s2_mode_d   = s1_mode_q;
            s2_vec_d    = s1_res_q;
            s2_sum_d    = tree_sum;
            out_valid_d = 1'b0;
            if (s2_valid_q) begin
                if (is_reduce(s2_mode_q)) begin
                    if (s2_last_q) begin
                        out_valid_d  = 1'b1;
                        out_last_d   = 1'b1;
                        out_scalar_d = acc_next;
                        out_sat_d    = sat_q || ovf_hi || ovf_lo;
                        out_vector_d = '0;
                        acc_d        = '0;
                        sat_d        = 1'b0;
                    end else begin
                        acc_d = acc_next;
                        sat_d = sat_q || ovf_hi || ovf_lo;
                    end
                end else begin
                    out_valid_d  = 1'b1;
                    out_last_d   = s2_last_q;
                    out_scalar_d = '0;
                    out_sat_d    = 1'b0;
                    out_vector_d = s2_vec_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_open_q   <= 1'b0;
            grp_mode_q   <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_mode_q    <= '0;
            s1_res_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_mode_q    <= '0;
            s2_vec_q     <= '0;
            s2_sum_q     <= '0;
            acc_q        <= '0;
            sat_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_sat_q    <= 1'b0;
            out_vector_q <= '0;
            out_scalar_q <= '0;
        end else begin
            grp_open_q   <= grp_open_d;
            grp_mode_q   <= grp_mode_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_mode_q    <= s1_mode_d;
            s1_res_q     <= s1_res_d;
            s2_valid_q   <= s2_valid_d;
            s2_last_q    <= s2_last_d;
            s2_mode_q    <= s2_mode_d;
            s2_vec_q     <= s2_vec_d;
            s2_sum_q     <= s2_sum_d;
            acc_q        <= acc_d;
            sat_q        <= sat_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_sat_q    <= out_sat_d;
            out_vector_q <= out_vector_d;
            out_scalar_q <= out_scalar_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_sat    = out_sat_q;
    assign out_vector = out_vector_q;
    assign out_scalar = out_scalar_q;

endmodule
